// File: rtl/prj7620_cfg_seq.sv
// PAJ7620 register-initialisation sequencer: walks the table, issues one I2C write per entry, retries NACKs.
// Optional delay-command entries (reg_addr 8'hFF) are enabled with `define PRJ7620_CFG_DELAY_EN.
module prj7620_cfg_seq #(
    parameter logic [6:0] DEV_ADDR  = 7'h73,
    parameter int          REG_NUM  = 51,
    parameter int          CNT_W    = 6,
    parameter int          GAP_CYC  = 1000,
    parameter int          MAX_RETRY = 3
) (
    input  logic             i2c_clk,
    input  logic             sys_rst,
    input  logic             cfg_start,
    input  logic [15:0]      tbl_data,
    output logic [CNT_W-1:0] tbl_idx,
    output logic [23:0]      cfg_data,
    output logic             i2c_start,
    input  logic             i2c_end,
    input  logic             i2c_ack_err,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [CNT_W:0]   reg_num
);

    localparam int               GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(REG_NUM - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
`ifdef PRJ7620_CFG_DELAY_EN
        , S_DELAY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tbl_idx_q, tbl_idx_d;
    logic [23:0]        cfg_data_q, cfg_data_d;
    logic [CNT_W:0]     reg_num_q, reg_num_d;
    logic [3:0]         retry_q, retry_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               entry_ok;
`ifdef PRJ7620_CFG_DELAY_EN
    logic [17:0]        dly_cnt_q, dly_cnt_d;
`endif

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        cfg_data_d = cfg_data_q;
        reg_num_d  = reg_num_q;
        retry_d    = retry_q;
        gap_cnt_d  = gap_cnt_q;
        entry_ok   = 1'b0;
`ifdef PRJ7620_CFG_DELAY_EN
        dly_cnt_d  = dly_cnt_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (cfg_start) begin
                    state_d   = S_LOAD;
                    tbl_idx_d = '0;
                    reg_num_d = '0;
                    retry_d   = '0;
                end
            end
            S_LOAD: begin
`ifdef PRJ7620_CFG_DELAY_EN
                if (tbl_data[15:8] == 8'hFF) begin
                    state_d   = S_DELAY;
                    dly_cnt_d = '0;
                end else begin
                    cfg_data_d = {DEV_ADDR, 1'b0, tbl_data};
                    state_d    = S_ISSUE;
                end
`else
                cfg_data_d = {DEV_ADDR, 1'b0, tbl_data};
                state_d    = S_ISSUE;
`endif
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (i2c_end) begin
                    if (!i2c_ack_err) begin
                        entry_ok = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + 1'b1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`ifdef PRJ7620_CFG_DELAY_EN
            // The table index is held here, so tbl_data still carries this entry's delay count.
            S_DELAY: begin
                if (dly_cnt_q == {tbl_data[7:0], 10'b0}) begin
                    entry_ok = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Shared completion path for an acknowledged write or a finished delay entry.
        if (entry_ok) begin
            reg_num_d = reg_num_q + 1'b1;
            if (tbl_idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                tbl_idx_d = tbl_idx_q + 1'b1;
                retry_d   = '0;
                gap_cnt_d = '0;
                state_d   = S_GAP;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge i2c_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            tbl_idx_q  <= '0;
            cfg_data_q <= '0;
            reg_num_q  <= '0;
            retry_q    <= '0;
            gap_cnt_q  <= '0;
`ifdef PRJ7620_CFG_DELAY_EN
            dly_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            cfg_data_q <= cfg_data_d;
            reg_num_q  <= reg_num_d;
            retry_q    <= retry_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef PRJ7620_CFG_DELAY_EN
            dly_cnt_q  <= dly_cnt_d;
`endif
        end
    end

    assign tbl_idx   = tbl_idx_q;
    assign cfg_data  = cfg_data_q;
    assign reg_num   = reg_num_q;
    assign i2c_start = (state_q == S_ISSUE);
    assign cfg_done  = (state_q == S_DONE);
    assign cfg_err   = (state_q == S_ERR);
    assign cfg_busy  = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule

// File: tb/tb_prj7620_cfg_seq.sv
// Directed bench for prj7620_cfg_seq: behavioural I2C master with scripted NACKs, checks on the falling edge.
module tb_prj7620_cfg_seq;

    localparam int REG_NUM   = 4;
    localparam int CNT_W     = 6;
    localparam int GAP_CYC   = 4;
    localparam int MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_start = 1'b0;
    logic [15:0]      tbl_data;
    logic [CNT_W-1:0] tbl_idx;
    logic [23:0]      cfg_data;
    logic             i2c_start;
    logic             i2c_end = 1'b0;
    logic             i2c_ack_err = 1'b0;
    logic             cfg_busy, cfg_done, cfg_err;
    logic [CNT_W:0]   reg_num;

    logic [15:0] tbl_mem [REG_NUM];
    assign tbl_data = tbl_mem[tbl_idx[1:0]];

    prj7620_cfg_seq #(
        .DEV_ADDR(7'h73), .REG_NUM(REG_NUM), .CNT_W(CNT_W),
        .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i2c_clk(clk), .sys_rst(rst), .cfg_start(cfg_start),
        .tbl_data(tbl_data), .tbl_idx(tbl_idx), .cfg_data(cfg_data),
        .i2c_start(i2c_start), .i2c_end(i2c_end), .i2c_ack_err(i2c_ack_err),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .reg_num(reg_num)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction log kept by the master model; the main flow only reads it.
    logic [23:0] log_q [256];
    int          start_cyc [256];
    int          end_cyc [256];
    int          start_cnt = 0;
    int          end_cnt = 0;
    int          run_base = 0;
    logic [23:0] nack_data = 24'h0;
    int          nack_times = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    // The master NACKs nack_data for its first nack_times attempts in the current run,
    // and throws in a stray ack_err without i2c_end mid-transaction.
    initial begin : i2c_master
        forever begin : one_cycle
            logic [23:0] cur;
            int          prev;
            @(negedge clk);
            if (i2c_start === 1'b1) begin
                cur = cfg_data;
                log_q[start_cnt] = cur;
                start_cyc[start_cnt] = cyc;
                start_cnt++;
                prev = 0;
                for (int i = run_base; i < start_cnt - 1; i++)
                    if (log_q[i] == cur) prev++;
                repeat (5) @(negedge clk);
                i2c_ack_err = 1'b1;
                @(negedge clk);
                i2c_ack_err = 1'b0;
                repeat (4) @(negedge clk);
                i2c_end = 1'b1;
                i2c_ack_err = (cur == nack_data) && (prev < nack_times);
                @(negedge clk);
                i2c_end = 1'b0;
                i2c_ack_err = 1'b0;
                end_cyc[end_cnt] = cyc;
                end_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("finish_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ends(input int target, input int budget);
        int n = 0;
        while (end_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("end_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [23:0] exp_clean [4];
        logic [23:0] exp_retry [6];
        logic [23:0] exp_abort [6];
        int base;
        int base_end;

        exp_clean = '{24'hE6EF00, 24'hE63707, 24'hE63817, 24'hE63906};
        exp_retry = '{24'hE6EF00, 24'hE63707, 24'hE63707, 24'hE63707, 24'hE63817, 24'hE63906};
        exp_abort = '{24'hE6EF00, 24'hE63707, 24'hE63817, 24'hE63817, 24'hE63817, 24'hE63817};
        tbl_mem = '{16'hEF00, 16'h3707, 16'h3817, 16'h3906};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tbl_idx",  32'(tbl_idx), 32'd0);
        check("rst_cfg_data", 32'(cfg_data), 32'd0);
        check("rst_start",    32'(i2c_start), 32'd0);
        check("rst_busy",     32'(cfg_busy), 32'd0);
        check("rst_done",     32'(cfg_done), 32'd0);
        check("rst_err",      32'(cfg_err), 32'd0);
        check("rst_reg_num",  32'(reg_num), 32'd0);
        rst = 1'b0;

        // Clean run, with a cfg_start while busy (during WAIT of entry 1) that must be ignored
        base = start_cnt;
        run_base = base;
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("lat_no_start_yet", 32'(i2c_start), 32'd0);
        check("lat_busy",         32'(cfg_busy), 32'd1);
        @(negedge clk);
        check("lat_start_2cyc",   32'(i2c_start), 32'd1);
        check("lat_cfg_data",     32'(cfg_data), 32'hE6EF00);
        wait_starts(base + 2, 200);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_finish(2000);
        check("clean_starts", 32'(start_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("clean_data%0d", i), 32'(log_q[base + i]), 32'(exp_clean[i]));
        check("clean_done",    32'(cfg_done), 32'd1);
        check("clean_err",     32'(cfg_err), 32'd0);
        check("clean_busy",    32'(cfg_busy), 32'd0);
        check("clean_reg_num", 32'(reg_num), 32'd4);
        check("clean_tbl_idx", 32'(tbl_idx), 32'd3);

        // Re-run from DONE: entry 1 NACKed twice, then acknowledged
        base = start_cnt;
        run_base = base;
        nack_data = 24'hE63707;
        nack_times = 2;
        pulse_start();
        check("rerun_done_clr", 32'(cfg_done), 32'd0);
        check("rerun_busy",     32'(cfg_busy), 32'd1);
        wait_finish(2000);
        check("retry_starts", 32'(start_cnt - base), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("retry_data%0d", i), 32'(log_q[base + i]), 32'(exp_retry[i]));
        check("retry_done",    32'(cfg_done), 32'd1);
        check("retry_err",     32'(cfg_err), 32'd0);
        check("retry_reg_num", 32'(reg_num), 32'd4);

        // Retry budget exhausted on entry 2
        base = start_cnt;
        run_base = base;
        nack_data = 24'hE63817;
        nack_times = 4;
        pulse_start();
        wait_finish(2000);
        check("abort_starts", 32'(start_cnt - base), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("abort_data%0d", i), 32'(log_q[base + i]), 32'(exp_abort[i]));
        check("abort_err",     32'(cfg_err), 32'd1);
        check("abort_done",    32'(cfg_done), 32'd0);
        check("abort_busy",    32'(cfg_busy), 32'd0);
        check("abort_tbl_idx", 32'(tbl_idx), 32'd2);
        check("abort_reg_num", 32'(reg_num), 32'd2);
        repeat (40) @(negedge clk);
        check("abort_no_more_starts", 32'(start_cnt - base), 32'd6);
        check("abort_err_held",       32'(cfg_err), 32'd1);

        // Asynchronous reset in the GAP after entry 2, then a fresh run
        nack_times = 0;
        base = start_cnt;
        base_end = end_cnt;
        run_base = base;
        pulse_start();
        wait_ends(base_end + 3, 500);
        check("pre_rst_reg_num", 32'(reg_num), 32'd3);
        check("pre_rst_busy",    32'(cfg_busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",     32'(cfg_busy), 32'd0);
        check("arst_tbl_idx",  32'(tbl_idx), 32'd0);
        check("arst_cfg_data", 32'(cfg_data), 32'd0);
        check("arst_reg_num",  32'(reg_num), 32'd0);
        check("arst_start",    32'(i2c_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base = start_cnt;
        run_base = base;
        pulse_start();
        wait_finish(2000);
        check("after_rst_first", 32'(log_q[base]), 32'hE6EF00);
        check("after_rst_starts", 32'(start_cnt - base), 32'd4);
        check("after_rst_done",  32'(cfg_done), 32'd1);
        check("after_rst_reg_num", 32'(reg_num), 32'd4);

`ifdef PRJ7620_CFG_DELAY_EN
        // Delay entry FF02 (2048 cycles) in slot 1: no I2C write for it, but it counts as done
        tbl_mem = '{16'hEF00, 16'hFF02, 16'h3707, 16'h3906};
        base = start_cnt;
        base_end = end_cnt;
        run_base = base;
        pulse_start();
        wait_finish(6000);
        check("dly_starts", 32'(start_cnt - base), 32'd3);
        check("dly_next_data", 32'(log_q[base + 1]), 32'hE63707);
        check("dly_gap_ok", 32'((start_cyc[base + 1] - end_cyc[base_end]) >= 2048 + 2 * GAP_CYC), 32'd1);
        check("dly_reg_num", 32'(reg_num), 32'd4);
        check("dly_done", 32'(cfg_done), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
